// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/register-file bus for the write arbiter
//
// Purpose: bundles the requester handshake, the stall input and the
// register-file write port of reg_write_arbiter into one interface.
// Ports (signals):
//   i_req_valid   [NUM_REQ]                 per-requester write request
//   i_req_addr    [NUM_REQ*REG_ADDR_LENGTH] packed addresses, slice k = requester k
//   i_req_data    [NUM_REQ*REG_WIDTH]       packed write values, slice k = requester k
//   o_req_ready   [NUM_REQ]                 one-hot-or-zero grant
//   i_stall                                 register-file write port busy
//   o_reg_addr_w  [REG_ADDR_LENGTH]         write address
//   o_reg_val_w   [REG_WIDTH]               write value
//   o_write_en                              write enable
//   o_grant_id    [log2(NUM_REQ)]           requester owning the current write
//   o_write_count [16]                      wrapping count of issued writes
// Modports: master = requesters/register file side, slave = arbiter.
interface reg_write_arbiter_if #(
  parameter int REG_WIDTH       = 32,
  parameter int REG_ADDR_LENGTH = 8,
  parameter int NUM_REQ         = 4
);
  logic [NUM_REQ-1:0]                 i_req_valid;
  logic [NUM_REQ*REG_ADDR_LENGTH-1:0] i_req_addr;
  logic [NUM_REQ*REG_WIDTH-1:0]       i_req_data;
  logic [NUM_REQ-1:0]                 o_req_ready;
  logic                               i_stall;
  logic [REG_ADDR_LENGTH-1:0]         o_reg_addr_w;
  logic [REG_WIDTH-1:0]               o_reg_val_w;
  logic                               o_write_en;
  logic [$clog2(NUM_REQ)-1:0]         o_grant_id;
  logic [15:0]                        o_write_count;

  modport master (
    output i_req_valid, i_req_addr, i_req_data, i_stall,
    input  o_req_ready, o_reg_addr_w, o_reg_val_w, o_write_en, o_grant_id, o_write_count
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_data, i_stall,
    output o_req_ready, o_reg_addr_w, o_reg_val_w, o_write_en, o_grant_id, o_write_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for register-file writes
//
// Purpose: picks one of NUM_REQ write requesters per cycle in round-robin
// order and presents its address/value on the register-file write port one
// cycle later. Sustains one write per cycle under full load.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset
//   bus    reg_write_arbiter_if.slave (requests, grant, stall, write port, count)
module reg_write_arbiter #(
  parameter int REG_WIDTH       = 32,
  parameter int REG_ADDR_LENGTH = 8,
  parameter int NUM_REQ         = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  reg_write_arbiter_if.slave    bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] search_idx;
  logic            grant_vld;
  logic            grant_en;

  // Scan offsets from the highest down so the last hit, which wins, is the
  // requester closest to rr_ptr. NUM_REQ is a power of two, so the ID_W-bit
  // add wraps modulo NUM_REQ for free.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    search_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      search_idx = rr_ptr + ID_W'(i);
      if (bus.i_req_valid[search_idx]) begin
        grant_vld = 1'b1;
        grant_idx = search_idx;
      end
    end
  end

  // Stall only blocks new grants; a write already registered on the output
  // is left alone.
  assign grant_en = grant_vld && !i_rst && !bus.i_stall;

  always_comb begin
    bus.o_req_ready = '0;
    if (grant_en) begin
      bus.o_req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr            <= '0;
      bus.o_write_en    <= 1'b0;
      bus.o_reg_addr_w  <= '0;
      bus.o_reg_val_w   <= '0;
      bus.o_grant_id    <= '0;
      bus.o_write_count <= '0;
    end else begin
      bus.o_write_en <= grant_en;
      if (grant_en) begin
        rr_ptr            <= grant_idx + 1'b1;
        bus.o_reg_addr_w  <= bus.i_req_addr[grant_idx*REG_ADDR_LENGTH +: REG_ADDR_LENGTH];
        bus.o_reg_val_w   <= bus.i_req_data[grant_idx*REG_WIDTH +: REG_WIDTH];
        bus.o_grant_id    <= grant_idx;
        bus.o_write_count <= bus.o_write_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.REG_WIDTH(DW), .REG_ADDR_LENGTH(AW), .NUM_REQ(N)) bus ();

  reg_write_arbiter #(.REG_WIDTH(DW), .REG_ADDR_LENGTH(AW), .NUM_REQ(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // requester state
  bit             rq_v [N];
  logic [AW-1:0]  rq_a [N];
  logic [DW-1:0]  rq_d [N];
  bit             stall;

  // reference model state
  int             m_ptr;
  bit             m_we;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_val;
  int             m_id;
  int             m_cnt;
  int             m_grant;
  logic [N-1:0]   seen_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (rst || stall) return -1;
    for (int off = 0; off < N; off++) begin
      if (rq_v[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic bit any_valid();
    for (int k = 0; k < N; k++) if (rq_v[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic new_req(input int k);
    rq_v[k] = 1'b1;
    rq_a[k] = AW'($urandom_range(0, 7));
    rq_d[k] = $urandom;
  endtask

  // One clock: drive inputs after negedge, check ready, step model, then
  // check registered outputs at the following negedge.
  task automatic cycle();
    for (int k = 0; k < N; k++) begin
      bus.i_req_valid[k]          = rq_v[k];
      bus.i_req_addr[k*AW +: AW]  = rq_a[k];
      bus.i_req_data[k*DW +: DW]  = rq_d[k];
    end
    bus.i_stall = stall;
    #1;
    m_grant    = model_grant();
    seen_ready = bus.o_req_ready;
    check("ready", 64'(seen_ready), (m_grant < 0) ? 64'd0 : (64'd1 << m_grant));
    if (rst) begin
      m_ptr = 0; m_we = 0; m_addr = '0; m_val = '0; m_id = 0; m_cnt = 0;
    end else if (m_grant >= 0) begin
      m_we   = 1'b1;
      m_addr = rq_a[m_grant];
      m_val  = rq_d[m_grant];
      m_id   = m_grant;
      m_cnt  = (m_cnt + 1) % 65536;
      m_ptr  = (m_grant + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("write_en",    64'(bus.o_write_en),    64'(m_we));
    check("addr",        64'(bus.o_reg_addr_w),  64'(m_addr));
    check("val",         64'(bus.o_reg_val_w),   64'(m_val));
    check("grant_id",    64'(bus.o_grant_id),    64'(m_id));
    check("write_count", 64'(bus.o_write_count), 64'(m_cnt));
  endtask

  // Accepted requester either presents a fresh request or goes idle.
  task automatic retire(input bit renew);
    if (m_grant >= 0) begin
      if (renew) new_req(m_grant);
      else rq_v[m_grant] = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (any_valid() && n < 40) begin
      cycle();
      retire(1'b0);
      n++;
    end
    check("drain_done", 64'(any_valid()), 64'd0);
  endtask

  initial begin
    m_ptr = 0; m_we = 0; m_addr = '0; m_val = '0; m_id = 0; m_cnt = 0; m_grant = -1;
    rst = 1'b1;
    stall = 1'b0;
    for (int k = 0; k < N; k++) new_req(k);
    @(negedge clk);

    // reset with all requesters valid
    repeat (2) begin
      cycle();
      check("rst_ready", 64'(seen_ready), 64'd0);
      check("rst_we",    64'(bus.o_write_en), 64'd0);
      check("rst_cnt",   64'(bus.o_write_count), 64'd0);
    end
    rst = 1'b0;

    // full load: grants 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("full_grant", 64'(bus.o_grant_id), 64'(i % 4));
      check("full_we",    64'(bus.o_write_en), 64'd1);
      retire(1'b1);
    end
    check("full_cnt", 64'(bus.o_write_count), 64'd6);

    // mid-stream reset
    rst = 1'b1;
    cycle();
    check("mid_we",  64'(bus.o_write_en),    64'd0);
    check("mid_cnt", 64'(bus.o_write_count), 64'd0);
    rst = 1'b0;
    cycle();
    check("mid_restart", 64'(bus.o_grant_id), 64'd0);
    retire(1'b1);
    drain();

    // single requester 2
    rq_v[2] = 1'b1; rq_a[2] = 8'h05; rq_d[2] = 32'hDEADBEEF;
    cycle();
    check("single_ready", 64'(seen_ready), 64'h4);
    check("single_we",    64'(bus.o_write_en), 64'd1);
    check("single_addr",  64'(bus.o_reg_addr_w), 64'h05);
    check("single_val",   64'(bus.o_reg_val_w), 64'hDEADBEEF);
    check("single_id",    64'(bus.o_grant_id), 64'd2);
    retire(1'b0);

    // wrap: pointer now 3, requesters 1 and 3 -> 3 then 1
    new_req(1);
    new_req(3);
    cycle();
    check("wrap_first", 64'(bus.o_grant_id), 64'd3);
    retire(1'b0);
    cycle();
    check("wrap_second", 64'(bus.o_grant_id), 64'd1);
    retire(1'b0);

    // stall: requesters 0 and 1, 0 granted first, then 3 stalled cycles
    new_req(0);
    new_req(1);
    cycle();
    check("stall_pre", 64'(bus.o_grant_id), 64'd0);
    retire(1'b1);
    stall = 1'b1;
    repeat (3) begin
      cycle();
      check("stall_ready", 64'(seen_ready), 64'd0);
      check("stall_we",    64'(bus.o_write_en), 64'd0);
    end
    stall = 1'b0;
    cycle();
    check("stall_release", 64'(bus.o_grant_id), 64'd1);
    retire(1'b0);
    drain();

    // same address from every requester: serialised, never merged
    for (int k = 0; k < N; k++) begin
      rq_v[k] = 1'b1; rq_a[k] = 8'h3C; rq_d[k] = $urandom;
    end
    drain();

    // randomized traffic with stalls and occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) if (!rq_v[k] && ($urandom_range(0, 1) == 1)) new_req(k);
      stall = ($urandom_range(0, 4) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      cycle();
      retire(1'b0);
    end
    rst = 1'b0;
    stall = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 32, the width of a register value.
REQ-002 The block SHALL have parameter REG_ADDR_LENGTH, default 8, the width of a register address.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, the number of write requesters; legal values are powers of two, >= 2.
REQ-004 The block SHALL have port i_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-006 The block SHALL have port i_req_valid, input, NUM_REQ, per-requester write request.
REQ-007 The block SHALL have port i_req_addr, input, NUM_REQ*REG_ADDR_LENGTH, packed addresses; requester k occupies slice k.
REQ-008 The block SHALL have port i_req_data, input, NUM_REQ*REG_WIDTH, packed write values; requester k occupies slice k.
REQ-009 The block SHALL have port o_req_ready, input-accept, output, NUM_REQ, one-hot-or-zero grant to requesters.
REQ-010 The block SHALL have port i_stall, input, 1; register file write port unavailable this cycle.
REQ-011 The block SHALL have port o_reg_addr_w, output, REG_ADDR_LENGTH, register file write address.
REQ-012 The block SHALL have port o_reg_val_w, output, REG_WIDTH, register file write value.
REQ-013 The block SHALL have port o_write_en, output, 1, register file write enable.
REQ-014 The block SHALL have port o_grant_id, output, log2(NUM_REQ), index of the requester whose write is on the output.
REQ-015 The block SHALL have port o_write_count, output, 16, count of issued writes, wrapping.

Function
REQ-016 The block SHALL hold a round-robin pointer rr_ptr of log2(NUM_REQ) bits.
REQ-017 In a cycle with i_rst low, i_stall low and any i_req_valid high, it SHALL grant the first valid requester searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-018 o_req_ready SHALL be combinational: high only for the granted index; all zero when i_rst or i_stall is high, or no valid request.
REQ-019 A transfer SHALL complete on valid && ready in the same cycle; a requester holds valid, addr and data stable until accepted; valid does not depend on ready.
REQ-020 On a grant to k, rr_ptr SHALL become (k+1) mod NUM_REQ at the next edge; with no grant, rr_ptr holds.
REQ-021 On a grant to k, the cycle after SHALL show o_write_en=1, o_reg_addr_w and o_reg_val_w equal to requester k's slices, and o_grant_id=k; latency is exactly 1 cycle.
REQ-022 With no grant, the next cycle SHALL show o_write_en=0; o_reg_addr_w, o_reg_val_w and o_grant_id hold their previous values.
REQ-023 Back-to-back grants SHALL sustain one write per cycle with no bubble.
REQ-024 o_write_count SHALL increment by 1 in the cycle o_write_en rises or stays high, wrapping from 0xFFFF to 0x0000.
REQ-025 Same-address requests from several requesters SHALL be serialised in round-robin order with no merging; the last granted value wins in the register file.
REQ-026 i_stall asserted while o_write_en=1 SHALL NOT cancel the write already on the output; it blocks only new grants.

Reset
REQ-027 While i_rst is high at an edge, the block SHALL set rr_ptr=0, o_write_en=0, o_reg_addr_w=0, o_reg_val_w=0, o_grant_id=0, o_write_count=0.
REQ-028 A request valid in a reset cycle SHALL NOT be granted or written; any write in flight when reset is asserted SHALL be discarded.

Verification
REQ-029 The bench SHALL cover reset: i_rst=1 for 2 cycles with all valid -> o_req_ready=0, o_write_en=0, all outputs 0; first grant after release goes to requester 0.
REQ-030 The bench SHALL cover a single requester: req 2 valid, addr 0x05, data 0xDEADBEEF -> o_req_ready=0b0100 in cycle N; cycle N+1 shows o_write_en=1, addr 0x05, val 0xDEADBEEF, o_grant_id=2.
REQ-031 The bench SHALL cover full load: all 4 requesters valid continuously after reset -> grants 0,1,2,3,0,1 on consecutive cycles, o_write_en continuously 1, o_write_count=6 after 6 writes.
REQ-032 The bench SHALL cover wrap: with rr_ptr=3 and requesters 1 and 3 valid -> grant 3, then 1.
REQ-033 The bench SHALL cover stall: i_stall=1 for 3 cycles with requesters 0 and 1 valid after requester 0 was granted -> ready=0 and o_write_en=0 for those cycles; after release, grant 1 first.
REQ-034 The bench SHALL cover mid-stream reset: i_rst pulsed for 1 cycle during full load -> o_write_en=0 the next cycle, o_write_count=0, and grants restart at 0.
